// File: rtl/and4_result_checker.sv
// and4_result_checker
// In-fabric response checker for the 4-bit AND datapath. Each accepted sample
// compares z against x & y, tallies matches and mismatches over a run of
// NUM_VECTORS samples, captures the first mismatching sample and reports a
// final verdict once the run completes.
module and4_result_checker #(
   parameter int WIDTH       = 4,
   parameter int NUM_VECTORS = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   output logic             busy,
   output logic             done,
   output logic             all_pass,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err_valid,
   output logic [CNT_W-1:0] err_idx,
   output logic [WIDTH-1:0] err_x,
   output logic [WIDTH-1:0] err_y,
   output logic [WIDTH-1:0] err_z
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Index of the sample whose acceptance finishes the run.
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] idx;
   logic             accept;
   logic             match;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v)
         return v;
      else
         return v + CNT_W'(1);
   endfunction

   // A sample counts only while running; start in the same cycle discards it.
   assign accept = sample_valid && (state == S_RUN) && !start;
   assign match  = (z == (x & y));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic: start always (re)enters RUN; the last accept ends it.
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = S_RUN;
      end else begin
         case (state)
            S_RUN:   if (accept && (idx == LAST_IDX)) state_nxt = S_DONE;
            default: state_nxt = state;
         endcase
      end
   end

   // Status outputs decoded from the registered state and fail count.
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      all_pass = 1'b0;
      case (state)
         S_RUN:   busy = 1'b1;
         S_DONE: begin
            done     = 1'b1;
            all_pass = (fail_cnt == '0);
         end
         default: begin
            busy     = 1'b0;
            done     = 1'b0;
            all_pass = 1'b0;
         end
      endcase
   end

   // Tallies and first-mismatch capture; start clears, accepts update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         err_valid <= 1'b0;
         err_idx   <= '0;
         err_x     <= '0;
         err_y     <= '0;
         err_z     <= '0;
      end else if (start) begin
         idx       <= '0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         err_valid <= 1'b0;
         err_idx   <= '0;
         err_x     <= '0;
         err_y     <= '0;
         err_z     <= '0;
      end else if (accept) begin
         idx <= sat_inc(idx);
         if (match) begin
            pass_cnt <= sat_inc(pass_cnt);
         end else begin
            fail_cnt <= sat_inc(fail_cnt);
            // Only the first mismatch of a run is kept.
            if (!err_valid) begin
               err_valid <= 1'b1;
               err_idx   <= idx;
               err_x     <= x;
               err_y     <= y;
               err_z     <= z;
            end
         end
      end
   end

endmodule

// File: tb/tb_and4_result_checker.sv
// Testbench for and4_result_checker: table of directed steps with
// hand-computed expected outputs, plus hand-written restart and async-reset
// sequences.
module tb_and4_result_checker;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       sample_valid;
   logic [3:0] x, y, z;
   logic       busy, done, all_pass, err_valid;
   logic [7:0] pass_cnt, fail_cnt, err_idx;
   logic [3:0] err_x, err_y, err_z;

   int n_vec  = 0;
   int n_miss = 0;

   and4_result_checker #(
      .WIDTH(4),
      .NUM_VECTORS(4),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .sample_valid(sample_valid),
      .x(x),
      .y(y),
      .z(z),
      .busy(busy),
      .done(done),
      .all_pass(all_pass),
      .pass_cnt(pass_cnt),
      .fail_cnt(fail_cnt),
      .err_valid(err_valid),
      .err_idx(err_idx),
      .err_x(err_x),
      .err_y(err_y),
      .err_z(err_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        sv;
      logic [3:0]  a;
      logic [3:0]  b;
      logic [3:0]  c;
      logic [39:0] exp;
   } vec_t;

   vec_t tbl[$];

   // Expected output bundle:
   // {busy,done,all_pass,pass,fail,err_valid,err_idx,err_x,err_y,err_z}
   function automatic logic [39:0] E(input logic bs, input logic dn, input logic ap,
                                     input logic [7:0] p, input logic [7:0] f,
                                     input logic ev, input logic [7:0] ei,
                                     input logic [3:0] ex, input logic [3:0] ey,
                                     input logic [3:0] ez);
      return {bs, dn, ap, p, f, ev, ei, ex, ey, ez};
   endfunction

   function automatic vec_t V(input logic st, input logic sv, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] c,
                              input logic [39:0] exp);
      vec_t v;
      v.st = st; v.sv = sv; v.a = a; v.b = b; v.c = c; v.exp = exp;
      return v;
   endfunction

   function automatic logic [39:0] actual();
      return {busy, done, all_pass, pass_cnt, fail_cnt, err_valid, err_idx,
              err_x, err_y, err_z};
   endfunction

   task automatic check(input string name, input logic [39:0] exp);
      logic [39:0] act;
      act = actual();
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got bs/dn/ap/pass/fail/ev/eidx/ex/ey/ez=%h required %h",
                  name, act, exp);
      end
   endtask

   // Apply one cycle of inputs (changed at the falling edge), then settle
   // just past the next rising edge.
   task automatic drive(input logic st, input logic sv, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c);
      @(negedge clk);
      start        = st;
      sample_valid = sv;
      x            = a;
      y            = b;
      z            = c;
      @(posedge clk);
      #1;
   endtask

   localparam logic [39:0] ZERO = 40'h0;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0; x = '0; y = '0; z = '0;

      // Fill the step table.
      // Ignored samples in IDLE.
      tbl.push_back(V(0, 1, 4'h1, 4'h0, 4'h1, ZERO));
      tbl.push_back(V(0, 1, 4'h1, 4'h1, 4'h1, ZERO));
      // Run A: all pass.
      tbl.push_back(V(1, 0, 4'h0, 4'h0, 4'h0, E(1,0,0, 0,0, 0,0, 0,0,0)));
      tbl.push_back(V(0, 1, 4'h0, 4'h0, 4'h0, E(1,0,0, 1,0, 0,0, 0,0,0)));
      tbl.push_back(V(0, 1, 4'h1, 4'h0, 4'h0, E(1,0,0, 2,0, 0,0, 0,0,0)));
      tbl.push_back(V(0, 1, 4'h0, 4'h1, 4'h0, E(1,0,0, 3,0, 0,0, 0,0,0)));
      tbl.push_back(V(0, 1, 4'h1, 4'h1, 4'h1, E(0,1,1, 4,0, 0,0, 0,0,0)));
      // Extra samples after DONE are ignored.
      tbl.push_back(V(0, 1, 4'h1, 4'h1, 4'h0, E(0,1,1, 4,0, 0,0, 0,0,0)));
      tbl.push_back(V(0, 1, 4'h1, 4'h1, 4'h1, E(0,1,1, 4,0, 0,0, 0,0,0)));
      // Run B: single fault at index 2.
      tbl.push_back(V(1, 0, 4'h0, 4'h0, 4'h0, E(1,0,0, 0,0, 0,0, 0,0,0)));
      tbl.push_back(V(0, 1, 4'h0, 4'h0, 4'h0, E(1,0,0, 1,0, 0,0, 0,0,0)));
      tbl.push_back(V(0, 1, 4'h1, 4'h0, 4'h0, E(1,0,0, 2,0, 0,0, 0,0,0)));
      tbl.push_back(V(0, 1, 4'h0, 4'h1, 4'h1, E(1,0,0, 2,1, 1,2, 0,1,1)));
      tbl.push_back(V(0, 1, 4'h1, 4'h1, 4'h1, E(0,1,0, 3,1, 1,2, 0,1,1)));
      // Run C: faults at index 1 and 3, with a gap cycle; first capture kept.
      tbl.push_back(V(1, 0, 4'h0, 4'h0, 4'h0, E(1,0,0, 0,0, 0,0, 0,0,0)));
      tbl.push_back(V(0, 1, 4'h0, 4'h0, 4'h0, E(1,0,0, 1,0, 0,0, 0,0,0)));
      tbl.push_back(V(0, 1, 4'hF, 4'hA, 4'hF, E(1,0,0, 1,1, 1,1, 4'hF,4'hA,4'hF)));
      tbl.push_back(V(0, 0, 4'h6, 4'h6, 4'h0, E(1,0,0, 1,1, 1,1, 4'hF,4'hA,4'hF)));
      tbl.push_back(V(0, 1, 4'h3, 4'h5, 4'h1, E(1,0,0, 2,1, 1,1, 4'hF,4'hA,4'hF)));
      tbl.push_back(V(0, 1, 4'h7, 4'h7, 4'h0, E(0,1,0, 2,2, 1,1, 4'hF,4'hA,4'hF)));
      // Start together with sample_valid: the sample is discarded.
      tbl.push_back(V(1, 1, 4'h1, 4'h1, 4'h1, E(1,0,0, 0,0, 0,0, 0,0,0)));
      tbl.push_back(V(0, 1, 4'h2, 4'h3, 4'h2, E(1,0,0, 1,0, 0,0, 0,0,0)));

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("reset", ZERO);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].sv, tbl[i].a, tbl[i].b, tbl[i].c);
         check($sformatf("step%0d", i), tbl[i].exp);
      end

      // Restart after two accepted samples in RUN.
      drive(0, 1, 4'h4, 4'h4, 4'h4);
      check("pre_restart", E(1,0,0, 2,0, 0,0, 0,0,0));
      drive(1, 0, 4'h0, 4'h0, 4'h0);
      check("restart_clear", E(1,0,0, 0,0, 0,0, 0,0,0));
      drive(0, 1, 4'h9, 4'hC, 4'h8);
      drive(0, 1, 4'hF, 4'hF, 4'hF);
      drive(0, 1, 4'h5, 4'hA, 4'h0);
      check("restart_3_samples", E(1,0,0, 3,0, 0,0, 0,0,0));
      drive(0, 1, 4'hE, 4'h7, 4'h6);
      check("restart_done", E(0,1,1, 4,0, 0,0, 0,0,0));

      // Async reset mid-run with one recorded failure.
      drive(1, 0, 4'h0, 4'h0, 4'h0);
      drive(0, 1, 4'h1, 4'h0, 4'h1);
      check("pre_async_reset", E(1,0,0, 0,1, 1,0, 1,0,1));
      #2;
      rst_n = 1'b0;
      start = 1'b0; sample_valid = 1'b0;
      #1;
      check("async_reset_immediate", ZERO);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1, 4'h3, 4'h3, 4'h3);
      drive(0, 1, 4'h3, 4'h3, 4'h0);
      check("idle_after_reset", ZERO);
      drive(1, 0, 4'h0, 4'h0, 4'h0);
      drive(0, 1, 4'hC, 4'h6, 4'h4);
      check("run_after_reset", E(1,0,0, 1,0, 0,0, 0,0,0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
